// File: rtl/bpu_btb2_pkg.sv
// rtl/bpu_btb2_pkg.sv - predictor counter encodings, counter update rule and index-width helper
package bpu_btb2_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Saturating 2-bit update: taken moves toward ST, not-taken toward SNT.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] r;
    r = ctr;
    if (taken && ctr != CTR_ST) r = ctr + 2'b01;
    else if (!taken && ctr != CTR_SNT) r = ctr - 2'b01;
    return r;
  endfunction

  function automatic int idx_w(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/bpu_btb2_if.sv
// rtl/bpu_btb2_if.sv - IF/ID lookup and write-back bus of the BTB; perf counters only with BPU_PERF_EN
interface bpu_btb2_if #(
  parameter int ENTRIES = 32,
  parameter int PC_W    = 32,
  parameter int PERF_W  = 32
);
  localparam int IDX_W = bpu_btb2_pkg::idx_w(ENTRIES);

  logic             pause_i;
  logic             flush_i;
  logic [PC_W-1:0]  if_pc_4_out;
  logic [PC_W-1:0]  if_bpu_pc;
  logic [IDX_W-1:0] if_bpu_index;
  logic             if_bpu_hit;
  logic [1:0]       id_bpu_wen;
  logic [IDX_W-1:0] id_bpu_index;
  logic [PC_W-1:0]  id_pc_4_out;
  logic [PC_W-1:0]  if_new_pc;

`ifdef BPU_PERF_EN
  logic [PERF_W-1:0] perf_lookups;
  logic [PERF_W-1:0] perf_hits;
  logic [PERF_W-1:0] perf_updates;
  logic [PERF_W-1:0] perf_mispred;

  modport master (
    output pause_i, flush_i, if_pc_4_out, id_bpu_wen, id_bpu_index, id_pc_4_out, if_new_pc,
    input  if_bpu_pc, if_bpu_index, if_bpu_hit,
    input  perf_lookups, perf_hits, perf_updates, perf_mispred
  );
  modport slave (
    input  pause_i, flush_i, if_pc_4_out, id_bpu_wen, id_bpu_index, id_pc_4_out, if_new_pc,
    output if_bpu_pc, if_bpu_index, if_bpu_hit,
    output perf_lookups, perf_hits, perf_updates, perf_mispred
  );
`else
  logic w_unused_perf_w;
  assign w_unused_perf_w = (PERF_W > 0);

  modport master (
    output pause_i, flush_i, if_pc_4_out, id_bpu_wen, id_bpu_index, id_pc_4_out, if_new_pc,
    input  if_bpu_pc, if_bpu_index, if_bpu_hit
  );
  modport slave (
    input  pause_i, flush_i, if_pc_4_out, id_bpu_wen, id_bpu_index, id_pc_4_out, if_new_pc,
    output if_bpu_pc, if_bpu_index, if_bpu_hit
  );
`endif

endinterface

// File: rtl/bpu_btb2_prio_enc.sv
// rtl/bpu_btb2_prio_enc.sv - lowest-set-bit priority encoder with any-set flag
module bpu_btb2_prio_enc
  import bpu_btb2_pkg::*;
#(
  parameter int N = 32,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // Scan from the top so the lowest set bit is the last assignment to stick.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = W'(i);
    end
  end

  assign o_any = |i_vec;

endmodule

// File: rtl/bpu_btb2.sv
// rtl/bpu_btb2.sv - fully-associative BTB with 2-bit predictors, round-robin victims and flush
// Optional performance counters are built when BPU_PERF_EN is defined.
module bpu_btb2
  import bpu_btb2_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int PC_W    = 32,
  parameter int PERF_W  = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  bpu_btb2_if.slave  bus
);
  localparam int IDX_W = idx_w(ENTRIES);

  logic [ENTRIES-1:0] r_valid;
  logic [PC_W-1:0]    r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];
  logic [IDX_W-1:0]   r_rr_ptr;

  logic [ENTRIES-1:0] w_match;
  logic [ENTRIES-1:0] w_free;
  logic [IDX_W-1:0]   w_hit_idx;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_hit;
  logic               w_any_free;
  logic               w_pred_taken;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_match
    assign w_match[g] = r_valid[g] & (r_tag[g] == bus.if_pc_4_out);
  end
  assign w_free = ~r_valid;

  bpu_btb2_prio_enc #(.N(ENTRIES), .W(IDX_W)) u_match_enc (
    .i_vec (w_match),
    .o_idx (w_hit_idx),
    .o_any (w_hit)
  );

  bpu_btb2_prio_enc #(.N(ENTRIES), .W(IDX_W)) u_free_enc (
    .i_vec (w_free),
    .o_idx (w_free_idx),
    .o_any (w_any_free)
  );

  assign w_pred_taken     = w_hit & r_ctr[w_hit_idx][1];
  assign bus.if_bpu_hit   = w_hit;
  assign bus.if_bpu_pc    = w_pred_taken ? r_target[w_hit_idx] : bus.if_pc_4_out;
  assign bus.if_bpu_index = w_hit ? w_hit_idx : (w_any_free ? w_free_idx : r_rr_ptr);

  logic [IDX_W-1:0] w_slot;
  logic             w_taken;
  logic             w_existing;
  logic             w_wr;

  assign w_slot     = bus.id_bpu_index;
  assign w_taken    = bus.id_bpu_wen[0];
  assign w_existing = r_valid[w_slot] & (r_tag[w_slot] == bus.id_pc_4_out);
  assign w_wr       = bus.id_bpu_wen[1] & ~bus.pause_i & ~bus.flush_i;

  // Flush wins over a same-edge write; the victim pointer only moves when it was the slot consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= '0;
      r_rr_ptr <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (!bus.pause_i) begin
      if (bus.flush_i) begin
        r_valid <= '0;
        for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_WNT;
      end else if (bus.id_bpu_wen[1]) begin
        r_target[w_slot] <= bus.if_new_pc;
        if (w_existing) begin
          r_ctr[w_slot] <= ctr_next(r_ctr[w_slot], w_taken);
        end else begin
          r_tag[w_slot]   <= bus.id_pc_4_out;
          r_valid[w_slot] <= 1'b1;
          r_ctr[w_slot]   <= w_taken ? CTR_WT : CTR_WNT;
          if (w_slot == r_rr_ptr) r_rr_ptr <= r_rr_ptr + 1'b1;
        end
      end
    end
  end

`ifdef BPU_PERF_EN
  logic [PERF_W-1:0] r_perf_lookups;
  logic [PERF_W-1:0] r_perf_hits;
  logic [PERF_W-1:0] r_perf_updates;
  logic [PERF_W-1:0] r_perf_mispred;
  logic              w_redirect;
  logic              w_mispred;

  assign w_redirect = w_pred_taken & (r_target[w_hit_idx] != bus.if_pc_4_out);
  assign w_mispred  = w_wr & (w_existing ? (r_ctr[w_slot][1] != w_taken) : w_taken);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_lookups <= '0;
      r_perf_hits    <= '0;
      r_perf_updates <= '0;
      r_perf_mispred <= '0;
    end else if (!bus.pause_i) begin
      r_perf_lookups <= r_perf_lookups + 1'b1;
      if (w_redirect) r_perf_hits    <= r_perf_hits + 1'b1;
      if (w_wr)       r_perf_updates <= r_perf_updates + 1'b1;
      if (w_mispred)  r_perf_mispred <= r_perf_mispred + 1'b1;
    end
  end

  assign bus.perf_lookups = r_perf_lookups;
  assign bus.perf_hits    = r_perf_hits;
  assign bus.perf_updates = r_perf_updates;
  assign bus.perf_mispred = r_perf_mispred;
`else
  logic w_unused_perf_w;
  assign w_unused_perf_w = (PERF_W > 0);
`endif

endmodule

// File: tb/tb_bpu_btb2.sv
// tb/tb_bpu_btb2.sv - self-checking bench for bpu_btb2: vector table, corner sequences, random vs model
module tb_bpu_btb2;

  localparam int ENTRIES = 32;
  localparam int PC_W    = 32;
  localparam int PERF_W  = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bpu_btb2_if #(.ENTRIES(ENTRIES), .PC_W(PC_W), .PERF_W(PERF_W)) bus ();

  bpu_btb2 #(.ENTRIES(ENTRIES), .PC_W(PC_W), .PERF_W(PERF_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_rr;
  logic [31:0] m_lookups, m_hits, m_updates, m_mispred;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_rr = 0;
    m_lookups = '0; m_hits = '0; m_updates = '0; m_mispred = '0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit hit, output int idx,
                                   output logic [31:0] pred);
    hit = 1'b0; idx = m_rr;
    for (int i = 0; i < ENTRIES; i++)
      if (!hit && m_valid[i] && m_tag[i] == pc) begin hit = 1'b1; idx = i; end
    if (!hit) begin
      bit found = 1'b0;
      for (int i = 0; i < ENTRIES; i++)
        if (!found && !m_valid[i]) begin found = 1'b1; idx = i; end
    end
    pred = (hit && m_ctr[idx] >= 2) ? m_tgt[idx] : pc;
  endfunction

  function automatic void m_step(input bit p, input bit f, input logic [1:0] w, input int s,
                                 input logic [31:0] wpc, input logic [31:0] wtgt,
                                 input logic [31:0] lpc);
    bit h, ex, tk;
    int li;
    logic [31:0] pr;
    if (p) return;
    m_lookup(lpc, h, li, pr);
    m_lookups++;
    if (pr != lpc) m_hits++;
    if (f) begin
      for (int i = 0; i < ENTRIES; i++) begin m_valid[i] = 1'b0; m_ctr[i] = 1; end
      return;
    end
    if (!w[1]) return;
    tk = w[0];
    ex = m_valid[s] && m_tag[s] == wpc;
    m_updates++;
    if ((ex && ((m_ctr[s] >= 2) != tk)) || (!ex && tk)) m_mispred++;
    m_tgt[s] = wtgt;
    if (ex) begin
      if (tk) m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
      else    m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
    end else begin
      m_tag[s] = wpc; m_valid[s] = 1'b1; m_ctr[s] = tk ? 2 : 1;
      if (s == m_rr) m_rr = (m_rr + 1) % ENTRIES;
    end
  endfunction

  // All drive/advance calls start at posedge+1.
  task automatic drive(input bit p, input bit f, input logic [1:0] w, input int widx,
                       input logic [31:0] wpc, input logic [31:0] wtgt, input logic [31:0] lpc);
    bus.pause_i      = p;
    bus.flush_i      = f;
    bus.id_bpu_wen   = w;
    bus.id_bpu_index = widx[4:0];
    bus.id_pc_4_out  = wpc;
    bus.if_new_pc    = wtgt;
    bus.if_pc_4_out  = lpc;
    #4;
  endtask

  task automatic advance();
    bit p, f;
    logic [1:0] w;
    int s;
    logic [31:0] wpc, wtgt, lpc;
    p = bus.pause_i; f = bus.flush_i; w = bus.id_bpu_wen; s = int'(bus.id_bpu_index);
    wpc = bus.id_pc_4_out; wtgt = bus.if_new_pc; lpc = bus.if_pc_4_out;
    @(posedge clk);
    #1;
    m_step(p, f, w, s, wpc, wtgt, lpc);
  endtask

  task automatic chk_model(input string nm);
    bit h;
    int i;
    logic [31:0] pr;
    m_lookup(bus.if_pc_4_out, h, i, pr);
    chk({nm, " hit"}, 32'(bus.if_bpu_hit), 32'(h));
    chk({nm, " index"}, 32'(bus.if_bpu_index), i);
    chk({nm, " pc"}, bus.if_bpu_pc, pr);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 0, '0, '0, 32'h100);
    m_reset();
    chk("reset hit", 32'(bus.if_bpu_hit), 32'd0);
    chk("reset index", 32'(bus.if_bpu_index), 32'd0);
    chk("reset pc", bus.if_bpu_pc, 32'h100);
    reset_n = 1'b1;
    advance();
  endtask

`ifdef BPU_PERF_EN
  task automatic chk_perf(input string nm, input logic [31:0] l, input logic [31:0] h,
                          input logic [31:0] u, input logic [31:0] m);
    chk({nm, " lookups"}, bus.perf_lookups, l);
    chk({nm, " hits"},    bus.perf_hits, h);
    chk({nm, " updates"}, bus.perf_updates, u);
    chk({nm, " mispred"}, bus.perf_mispred, m);
  endtask
`endif

  typedef struct {
    bit          p;
    bit          f;
    logic [1:0]  w;
    int          widx;
    logic [31:0] wpc;
    logic [31:0] wtgt;
    logic [31:0] lpc;
    bit          eh;
    int          ei;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int k;
    tbl[0]  = '{1'b0, 1'b0, 2'b00, 0, 32'h0,   32'h0,   32'h100, 1'b0, 0, 32'h100};
    tbl[1]  = '{1'b0, 1'b0, 2'b11, 0, 32'h104, 32'h200, 32'h104, 1'b0, 0, 32'h104};
    tbl[2]  = '{1'b0, 1'b0, 2'b00, 0, 32'h0,   32'h0,   32'h104, 1'b1, 0, 32'h200};
    tbl[3]  = '{1'b0, 1'b0, 2'b00, 0, 32'h0,   32'h0,   32'h108, 1'b0, 1, 32'h108};
    tbl[4]  = '{1'b0, 1'b0, 2'b10, 0, 32'h104, 32'h200, 32'h104, 1'b1, 0, 32'h200};
    tbl[5]  = '{1'b0, 1'b0, 2'b11, 0, 32'h104, 32'h200, 32'h104, 1'b1, 0, 32'h104};
    tbl[6]  = '{1'b0, 1'b0, 2'b11, 0, 32'h104, 32'h200, 32'h104, 1'b1, 0, 32'h200};
    tbl[7]  = '{1'b0, 1'b0, 2'b10, 0, 32'h104, 32'h200, 32'h104, 1'b1, 0, 32'h200};
    tbl[8]  = '{1'b0, 1'b0, 2'b00, 0, 32'h0,   32'h0,   32'h104, 1'b1, 0, 32'h200};
    tbl[9]  = '{1'b0, 1'b0, 2'b10, 1, 32'h300, 32'h400, 32'h300, 1'b0, 1, 32'h300};
    tbl[10] = '{1'b0, 1'b0, 2'b00, 0, 32'h0,   32'h0,   32'h300, 1'b1, 1, 32'h300};
    tbl[11] = '{1'b1, 1'b0, 2'b11, 1, 32'h300, 32'h500, 32'h300, 1'b1, 1, 32'h300};
    tbl[12] = '{1'b0, 1'b0, 2'b00, 0, 32'h0,   32'h0,   32'h300, 1'b1, 1, 32'h300};
    tbl[13] = '{1'b0, 1'b1, 2'b11, 2, 32'h500, 32'h600, 32'h104, 1'b1, 0, 32'h200};
    tbl[14] = '{1'b0, 1'b0, 2'b00, 0, 32'h0,   32'h0,   32'h104, 1'b0, 0, 32'h104};
    tbl[15] = '{1'b0, 1'b0, 2'b00, 0, 32'h0,   32'h0,   32'h500, 1'b0, 0, 32'h500};

    drive(1'b1, 1'b0, 2'b00, 0, '0, '0, 32'h100);
    @(posedge clk);
    #1;
    do_reset();

    // Basic write/hysteresis/pause/flush vectors
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].p, tbl[i].f, tbl[i].w, tbl[i].widx, tbl[i].wpc, tbl[i].wtgt, tbl[i].lpc);
      chk($sformatf("vec%0d hit", i), 32'(bus.if_bpu_hit), 32'(tbl[i].eh));
      chk($sformatf("vec%0d index", i), 32'(bus.if_bpu_index), tbl[i].ei);
      chk($sformatf("vec%0d pc", i), bus.if_bpu_pc, tbl[i].epc);
      advance();
    end

    // Fill every slot, then round-robin replacement with wrap
    do_reset();
    for (int i = 0; i < ENTRIES + 3 + 29 + 1; i++) begin
      k = (i < ENTRIES) ? i : (i - ENTRIES) % ENTRIES;
      drive(1'b0, 1'b0, 2'b00, 0, '0, '0, 32'h1000 + 32'(i) * 4);
      chk($sformatf("alloc%0d hit", i), 32'(bus.if_bpu_hit), 32'd0);
      chk($sformatf("alloc%0d index", i), 32'(bus.if_bpu_index), k);
      bus.id_bpu_wen   = 2'b10;
      bus.id_bpu_index = bus.if_bpu_index;
      bus.id_pc_4_out  = bus.if_pc_4_out;
      bus.if_new_pc    = 32'h8000 + 32'(i) * 4;
      #1;
      advance();
      if (i == ENTRIES + 2) begin
        drive(1'b0, 1'b0, 2'b00, 0, '0, '0, 32'h1000);
        chk("evicted slot0 hit", 32'(bus.if_bpu_hit), 32'd0);
        chk("evicted slot0 index", 32'(bus.if_bpu_index), 32'd3);
        drive(1'b0, 1'b0, 2'b00, 0, '0, '0, 32'h100C);
        chk("kept slot3 hit", 32'(bus.if_bpu_hit), 32'd1);
        chk("kept slot3 index", 32'(bus.if_bpu_index), 32'd3);
        chk_model("kept slot3 model");
      end
    end

`ifdef BPU_PERF_EN
    do_reset();
    drive(1'b0, 1'b0, 2'b11, 0, 32'h104, 32'h200, 32'h999); advance();
    drive(1'b0, 1'b0, 2'b10, 1, 32'h108, 32'h300, 32'h999); advance();
    drive(1'b0, 1'b0, 2'b11, 0, 32'h104, 32'h200, 32'h999); advance();
    for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b0, 2'b00, 0, '0, '0, 32'h104); advance(); end
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 2'b11, 0, 32'h104, 32'h200, 32'h104); advance(); end
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b0, 2'b00, 0, '0, '0, 32'h999); advance(); end
    chk_perf("perf seq", 32'd10, 32'd2, 32'd3, 32'd1);
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit p, f;
      logic [1:0] w;
      int widx;
      logic [31:0] lpc, wpc;
      p    = ($urandom_range(0, 9) == 0);
      f    = ($urandom_range(0, 29) == 0);
      w    = 2'($urandom_range(0, 3));
      lpc  = 32'h4000 + 32'($urandom_range(0, 11)) * 4;
      wpc  = ($urandom_range(0, 3) == 0) ? 32'h4000 + 32'($urandom_range(0, 11)) * 4 : lpc;
      widx = $urandom_range(0, ENTRIES - 1);
      drive(p, f, w, widx, wpc, 32'h9000 + 32'($urandom_range(0, 255)) * 4, lpc);
      chk_model($sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        bus.id_bpu_index = bus.if_bpu_index;
        #1;
      end
      advance();
    end
`ifdef BPU_PERF_EN
    chk_perf("perf rand", m_lookups, m_hits, m_updates, m_mispred);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
